// File: rtl/mmss_display_scan_pkg.sv
// Shared constants for the MM:SS seven-segment scanner: segment encodings
// (active-low, {g,f,e,d,c,b,a}) and the digit count.
package mmss_display_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entries 10-15 are not BCD and show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Index 0 = units of seconds ... index 3 = tens of minutes, matching an[].
  typedef logic [NUM_DIGITS-1:0][3:0] snap_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode.
module bcd_to_seg7
  import mmss_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/mmss_display_scan.sv
// Time-multiplexed MM:SS display driver: per-digit dwell with leading blank
// interval, frame-coherent input snapshot, registered active-low outputs.
module mmss_display_scan
  import mmss_display_scan_pkg::*;
#(
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic [3:0] q4,
  input  logic       lzb,
  input  logic       colon_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  if (DWELL < 4) begin : g_bad_dwell
    $error("DWELL must be >= 4");
  end
  if (BLANK_CYC >= DWELL) begin : g_bad_blank
    $error("BLANK_CYC must be < DWELL");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          last_cyc;
  logic          blank_cyc;
  logic          lz_hide;
  logic [3:0]    sel_bcd;
  logic [6:0]    dec_seg;

  assign last_cyc  = (cnt_q == CW'(DWELL - 1));
  assign blank_cyc = ({1'b0, cnt_q} < (CW + 1)'(BLANK_CYC));
  assign sel_bcd   = snap_q[idx_q];
  assign lz_hide   = (idx_q == 2'd3) && lzb && (snap_q[3] == 4'd0);

  bcd_to_seg7 u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    cnt_d  = last_cyc ? '0 : cnt_q + CW'(1);
    idx_d  = last_cyc ? idx_q + 2'd1 : idx_q;
    // Capture only at the very end of a frame so a frame never mixes two times.
    snap_d = (last_cyc && idx_q == 2'd3) ? {q1, q2, q3, q4} : snap_q;

    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!blank_cyc) begin
      dp_d = !((idx_q == 2'd2) && colon_en);
      if (!lz_hide) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= 4'hF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/mmss_display_scan.md
MMSS_DISPLAY_SCAN -- requirements
Module: mmss_display_scan

Interface
REQ-001 Parameter DWELL, default 50000, clock cycles each digit is selected; SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each dwell; SHALL be < DWELL.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 q1  input  4  BCD tens of minutes (0-5 nominal).
REQ-006 q2  input  4  BCD units of minutes (0-9 nominal).
REQ-007 q3  input  4  BCD tens of seconds (0-5 nominal).
REQ-008 q4  input  4  BCD units of seconds (0-9 nominal).
REQ-009 lzb  input  1  when high, blank a zero tens-of-minutes digit.
REQ-010 colon_en  input  1  when high, light the decimal point on the units-of-minutes digit.
REQ-011 an  output  4  active-low anode selects: an[3]=q1, an[2]=q2, an[1]=q3, an[0]=q4.
REQ-012 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  active-low decimal point.

Function
REQ-014 Dwell counter cnt SHALL count 0..DWELL-1 and wrap to 0; digit index idx (2 bits) SHALL increment mod 4 on each wrap.
REQ-015 On the cycle where idx==3 and cnt==DWELL-1, the block SHALL capture q1..q4 into a snapshot; only the snapshot drives the display, so a frame never mixes two counter values.
REQ-016 an, seg and dp SHALL be registered and SHALL reflect the (idx, cnt, snapshot, lzb, colon_en) values of the previous cycle, giving one cycle of latency.
REQ-017 While cnt < BLANK_CYC: an=4'b1111, seg=7'b1111111, dp=1.
REQ-018 Otherwise: an SHALL be all ones except bit idx=0; seg SHALL be the decode of the snapshot digit selected by idx.
REQ-019 Decode (hex, gfedcba active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-020 Any digit value 10-15 SHALL decode to a dash, 3F (segment g only).
REQ-021 When idx==3, lzb==1 and snapshot q1==0: an[3] SHALL stay 1 and seg SHALL be 7F for that dwell.
REQ-022 dp SHALL be 0 only when idx==2, cnt >= BLANK_CYC and colon_en==1; otherwise dp SHALL be 1.
REQ-023 Input changes outside the capture cycle SHALL NOT affect outputs until the next capture.

Reset
REQ-024 While reset==0 at a clock edge: cnt=0, idx=0, snapshot=all zeros, an=4'b1111, seg=7'b1111111, dp=1.
REQ-025 After reset, the first frame SHALL display zeros from the cleared snapshot; live values appear from the second frame onward.
REQ-026 Reset asserted mid-dwell or mid-frame SHALL take effect at the next edge with no partial-digit output afterwards.

Structure
REQ-027 A shared package SHALL hold the 7-bit segment encodings for digits 0-9, the dash (3F), the blank (7F) and the digit count (4).
REQ-028 The decode SHALL be a separate combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out), instantiated once.
REQ-029 The counters, snapshot register and output registers SHALL all reside in mmss_display_scan.

Verification
REQ-030 With DWELL=8, BLANK_CYC=2 and inputs 1,2,3,4 held, after two frames: each dwell shows 2 blank cycles, then an=1110/seg=19, 1101/30, 1011/24, 0111/79, in turn.
REQ-031 Change q4 from 4 to 7 mid-frame: the displayed digit SHALL stay 19 until after the next capture cycle, then SHALL show 78.
REQ-032 Apply q1=0 with lzb=1: the idx 3 dwell SHALL show an=1111, seg=7F. With lzb=0, the same dwell SHALL show an=0111, seg=40.
REQ-033 Apply q2=4'hC with colon_en=1: the idx 2 dwell SHALL show seg=3F and dp=0; every other dwell SHALL show dp=1.
REQ-034 Assert reset during an idx 2 dwell: at the next edge an=1111, seg=7F, dp=1, and the following frame SHALL display all zeros (seg=40).
